fetch_unit: RTL and testbench

- Instruction-fetch stage of the in-order RISC-V pipeline, and the consumer of the branch unit's redirect interface (b_taken / b_pc).
- Holds the architectural fetch PC and issues one instruction-memory request at a time.
- Loads the IF/ID pipeline register and, on a taken branch, redirects the PC and squashes wrong-path work.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request
// in flight, loads IF/ID and handles branch redirects with wrong-path squash.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        b_taken,
    input  logic [31:0] b_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        flush
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            flush_q, flush_d;
    logic            accept;

    // Request is a pure function of state; held low while reset is asserted.
    assign imem_req  = rst_n && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_valid = ifid_valid_q;
    assign flush       = flush_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        flush_d      = b_taken;

        if (b_taken) begin
            // Redirect beats stall; an in-flight response must still be drained.
            pc_d         = b_pc & ALIGN_MASK;
            ifid_valid_d = 1'b0;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            unique case (state_q)
                S_FETCH: state_d = accept ? S_DROP : S_FETCH;
                S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DROP;
                S_HOLD:  state_d = S_FETCH;
                S_DROP:  state_d = imem_rvalid ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(PC_STEP);
                        state_d  = S_WAIT;
                    end
                    if (!stall) ifid_valid_d = 1'b0;
                end
                S_WAIT: begin
                    if (imem_rvalid && stall) begin
                        hold_pc_d    = req_pc_q;
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else if (imem_rvalid) begin
                        ifid_pc_d    = req_pc_q;
                        ifid_instr_d = imem_rdata;
                        ifid_valid_d = 1'b1;
                        state_d      = S_FETCH;
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_pc_d    = hold_pc_q;
                        ifid_instr_d = hold_instr_q;
                        ifid_valid_d = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_d = S_FETCH;
                    if (!stall) ifid_valid_d = 1'b0;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            flush_q      <= flush_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset/wrap sequences and a
// randomized run against a transaction-level model with a simple memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_taken, stall, imem_ready, imem_rvalid;
    logic [31:0] b_pc, imem_rdata;
    logic        imem_req, if_id_valid, flush;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .b_taken(b_taken), .b_pc(b_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                           input logic ef);
        logic bad;
        n_vec++;
        bad = (imem_req !== er) || (er && imem_addr !== ea) || (if_id_valid !== ev) ||
              (if_id_pc !== ep) || (if_id_instr !== ei) || (flush !== ef);
        if (bad) begin
            n_bad++;
            $display("FAIL %s @%0t: got req=%b addr=%h v=%b pc=%h ins=%h fl=%b, want req=%b addr=%h v=%b pc=%h ins=%h fl=%b",
                     tag, $time, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, flush,
                     er, ea, ev, ep, ei, ef);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic st, bt; logic [31:0] bp; logic rdy, rv; logic [31:0] rd;
        logic er; logic [31:0] ea; logic ev; logic [31:0] ep, ei; logic ef;
    } vec_t;

    function automatic vec_t row(input logic st, input logic bt, input logic [31:0] bp,
                                 input logic rdy, input logic rv, input logic [31:0] rd,
                                 input logic er, input logic [31:0] ea, input logic ev,
                                 input logic [31:0] ep, input logic [31:0] ei, input logic ef);
        vec_t r;
        r.st = st; r.bt = bt; r.bp = bp; r.rdy = rdy; r.rv = rv; r.rd = rd;
        r.er = er; r.ea = ea; r.ev = ev; r.ep = ep; r.ei = ei; r.ef = ef;
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_req_pc, m_hold_pc, m_hold_instr, m_ifpc, m_ifinstr;
    logic        m_out, m_stale, m_hold_v, m_v, m_flush;
    logic        env_pending;
    logic [31:0] env_addr;
    int unsigned env_due, cyc, lat_min, lat_max;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5EED_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_hold_v = 1'b0;
        m_req_pc = '0; m_hold_pc = '0; m_hold_instr = '0;
        m_v = 1'b0; m_ifpc = '0; m_ifinstr = NOP; m_flush = 1'b0;
        env_pending = 1'b0;
    endtask

    // One clock of the fetch contract: outstanding request, stale flag, 1-deep hold.
    task automatic model_step(input logic st, input logic bt, input logic [31:0] bp,
                              input logic acc, input logic rv, input logic [31:0] rd);
        logic delivered;
        delivered = m_out && rv;
        m_flush = bt;
        if (bt) begin
            m_pc = {bp[31:2], 2'b00};
            m_v = 1'b0;
            m_hold_v = 1'b0;
            if (acc) begin m_out = 1'b1; m_stale = 1'b1; end
            else if (delivered) m_out = 1'b0;
            else if (m_out) m_stale = 1'b1;
        end else begin
            if (delivered) m_out = 1'b0;
            if (delivered && !m_stale && !st) begin
                m_ifpc = m_req_pc; m_ifinstr = rd; m_v = 1'b1;
            end else if (delivered && !m_stale) begin
                m_hold_v = 1'b1; m_hold_pc = m_req_pc; m_hold_instr = rd;
            end else if (m_hold_v && !st) begin
                m_ifpc = m_hold_pc; m_ifinstr = m_hold_instr; m_v = 1'b1; m_hold_v = 1'b0;
            end else if (!st) begin
                m_v = 1'b0;
            end
            if (acc) begin
                m_out = 1'b1; m_stale = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic mcycle(input logic st, input logic bt, input logic [31:0] bp, input logic rdy);
        logic rv, ereq, acc;
        logic [31:0] rd;
        @(negedge clk);
        rv = env_pending && (cyc == env_due);
        rd = rv ? mdata(env_addr) : 32'($urandom);
        stall = st; b_taken = bt; b_pc = bp; imem_ready = rdy;
        imem_rvalid = rv; imem_rdata = rd;
        ereq = !m_out && !m_hold_v;
        #1 compare("model", ereq, m_pc, m_v, m_ifpc, m_ifinstr, m_flush);
        acc = ereq && rdy;
        if (rv) env_pending = 1'b0;
        if (acc) begin
            env_pending = 1'b1;
            env_addr = m_pc;
            env_due = cyc + $urandom_range(lat_max, lat_min);
        end
        model_step(st, bt, bp, acc, rv, rd);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic bt, input logic [31:0] bp,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        stall = st; b_taken = bt; b_pc = bp; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    endtask

    initial begin
        vec_t tbl[15];
        tbl[0]  = row(0, 0, 32'h0,    1, 0, 32'h0,        1, 32'h100,  0, 32'h0,   NOP,          0);
        tbl[1]  = row(0, 0, 32'h0,    0, 1, 32'hCAFE0100, 0, 32'h0,    0, 32'h0,   NOP,          0);
        tbl[2]  = row(1, 0, 32'h0,    1, 0, 32'h0,        1, 32'h104,  1, 32'h100, 32'hCAFE0100, 0);
        tbl[3]  = row(1, 0, 32'h0,    0, 1, 32'hCAFE0104, 0, 32'h0,    1, 32'h100, 32'hCAFE0100, 0);
        tbl[4]  = row(1, 0, 32'h0,    1, 0, 32'h0,        0, 32'h0,    1, 32'h100, 32'hCAFE0100, 0);
        tbl[5]  = row(0, 0, 32'h0,    1, 0, 32'h0,        0, 32'h0,    1, 32'h100, 32'hCAFE0100, 0);
        tbl[6]  = row(0, 0, 32'h0,    1, 0, 32'h0,        1, 32'h108,  1, 32'h104, 32'hCAFE0104, 0);
        tbl[7]  = row(0, 1, 32'h2002, 0, 0, 32'h0,        0, 32'h0,    0, 32'h104, 32'hCAFE0104, 0);
        tbl[8]  = row(0, 0, 32'h0,    0, 1, 32'hCAFE0108, 0, 32'h0,    0, 32'h104, 32'hCAFE0104, 1);
        tbl[9]  = row(0, 0, 32'h0,    0, 0, 32'h0,        1, 32'h2000, 0, 32'h104, 32'hCAFE0104, 0);
        tbl[10] = row(0, 0, 32'h0,    1, 0, 32'h0,        1, 32'h2000, 0, 32'h104, 32'hCAFE0104, 0);
        tbl[11] = row(1, 0, 32'h0,    0, 1, 32'hCAFE2000, 0, 32'h0,    0, 32'h104, 32'hCAFE0104, 0);
        tbl[12] = row(1, 1, 32'h3000, 0, 0, 32'h0,        0, 32'h0,    0, 32'h104, 32'hCAFE0104, 0);
        tbl[13] = row(1, 0, 32'h0,    0, 0, 32'h0,        1, 32'h3000, 0, 32'h104, 32'hCAFE0104, 1);
        tbl[14] = row(0, 0, 32'h0,    0, 0, 32'h0,        1, 32'h3000, 0, 32'h104, 32'hCAFE0104, 0);

        cyc = 0; lat_min = 1; lat_max = 1;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 compare("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].st, tbl[i].bt, tbl[i].bp, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            #1 compare($sformatf("table[%0d]", i), tbl[i].er, tbl[i].ea, tbl[i].ev,
                       tbl[i].ep, tbl[i].ei, tbl[i].ef);
        end

        // Reset while a request to 0x3000 is outstanding, with a late response.
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 1, 32'hBAD0BAD0);
        #1 compare("rst_mid_wait", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
        @(negedge clk);
        #1 compare("rst_late_rvalid", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 1, 32'hBAD0BAD0);
        #1 compare("post_rst_req", 1'b1, RST_PC, 1'b0, 32'h0, NOP, 1'b0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1 compare("post_rst_ignore", 1'b1, RST_PC, 1'b0, 32'h0, NOP, 1'b0);

        // Model-driven from here on; DUT sits in FETCH at RESET_PC, IF/ID empty.
        model_reset();
        mcycle(0, 1, 32'hFFFF_FFFF, 0);
        mcycle(0, 0, 32'h0, 1);
        mcycle(0, 0, 32'h0, 0);
        compare("pc_wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, mdata(32'hFFFF_FFFC), 1'b0);

        // Redirect in the same cycle as an accepted request must drop its response.
        mcycle(0, 1, 32'h0000_4001, 1);
        mcycle(0, 0, 32'h0, 0);
        mcycle(0, 0, 32'h0, 1);
        mcycle(0, 0, 32'h0, 0);
        compare("fetch_accept_redirect", 1'b1, 32'h4004, 1'b1, 32'h4000, mdata(32'h4000), 1'b0);

        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            mcycle(($urandom_range(3, 0) == 0), ($urandom_range(11, 0) == 0),
                   32'($urandom), ($urandom_range(9, 0) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
